// File: rtl/map_pkg.sv
// Shared types and constants for the tile map RAM and its write-port arbiter.
package map_pkg;

  localparam int MAP_ROWS = 30;
  localparam int MAP_COLS = 40;
  localparam int TILE_W   = 4;
  localparam int ROW_W    = 160;

  typedef logic [TILE_W-1:0] tile_t;
  typedef logic [ROW_W-1:0]  row_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    MODIFY = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } arb_state_t;

  // Bit position of the LSB of tile x within a row; x=0 is the MSB nibble.
  function automatic int unsigned nib_lsb(input logic [5:0] x);
    return ROW_W - TILE_W - TILE_W * int'(x);
  endfunction

endpackage

// File: rtl/map_tile_arbiter_rr_arbiter.sv
// Request arbiter for the tile map write port.
// Default: round-robin starting at ptr. With MAP_TILE_ARB_FIXED_PRIO_EN
// defined the lowest set index always wins and ptr is ignored.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

`ifdef MAP_TILE_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // Pick the winner: first set bit at/after ptr, then wrap to the lowest set bit.
  always_comb begin
    logic found;
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    found     = 1'b0;
    grant_idx = '0;
`ifndef MAP_TILE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
        grant_idx = IDX_W'(i);
        found     = 1'b1;
      end
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        grant_idx = IDX_W'(i);
        found     = 1'b1;
      end
    end
    grant            = '0;
    grant[grant_idx] = found;
  end

endmodule

// File: rtl/map_tile_arbiter.sv
// Owner of the tile map RAM write port (port B). Serialises single-tile
// read-modify-write updates from several requesters and returns the
// replaced tile code. Optional build macro: MAP_TILE_ARB_FIXED_PRIO_EN
// (strict fixed priority instead of round-robin).
module map_tile_arbiter
  import map_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ROWS    = MAP_ROWS,
  parameter int COLS    = MAP_COLS,
  parameter int RD_LAT  = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*6-1:0] req_x,
  input  logic [NUM_REQ*5-1:0] req_y,
  input  logic [NUM_REQ*4-1:0] req_tile,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [3:0]           old_tile,
  output logic                 busy,
  output logic [4:0]           ram_addr,
  output logic [159:0]         ram_wrdata,
  output logic                 ram_wren,
  input  logic [159:0]         ram_rddata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [5:0]         x_q, x_d;
  tile_t              tile_q, tile_d;
  logic [1:0]         rd_cnt_q, rd_cnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  tile_t              old_tile_q, old_tile_d;
  logic               busy_q, busy_d;
  logic [4:0]         ram_addr_q, ram_addr_d;
  row_t               ram_wrdata_q, ram_wrdata_d;
  logic               ram_wren_q, ram_wren_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [5:0]         sel_x;
  logic [4:0]         sel_y;
  tile_t              sel_tile;
  logic [7:0]         nib_sh;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign sel_x    = req_x[int'(arb_idx)*6 +: 6];
  assign sel_y    = req_y[int'(arb_idx)*5 +: 5];
  assign sel_tile = req_tile[int'(arb_idx)*4 +: 4];
  assign nib_sh   = 8'(nib_lsb(x_q));

  // Next-state and registered-output logic of the read-modify-write sequencer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gidx_d       = gidx_q;
    x_d          = x_q;
    tile_d       = tile_q;
    rd_cnt_d     = rd_cnt_q;
    done_d       = '0;
    err_d        = 1'b0;
    old_tile_d   = old_tile_q;
    ram_addr_d   = ram_addr_q;
    ram_wrdata_d = ram_wrdata_q;
    ram_wren_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          gidx_d = arb_idx;
          x_d    = sel_x;
          tile_d = sel_tile;
          if (int'(sel_x) >= COLS || int'(sel_y) >= ROWS) begin
            // Out-of-range request: complete immediately with err, no RAM access.
            state_d    = ERR;
            done_d     = arb_grant;
            err_d      = 1'b1;
            old_tile_d = '0;
          end else begin
            state_d    = READ;
            ram_addr_d = sel_y;
            rd_cnt_d   = 2'(RD_LAT - 1);
          end
        end
      end
      READ: begin
        if (rd_cnt_q == 2'd0) state_d = MODIFY;
        else                  rd_cnt_d = rd_cnt_q - 2'd1;
      end
      MODIFY: begin
        old_tile_d   = tile_t'(ram_rddata >> nib_sh);
        ram_wrdata_d = (ram_rddata & ~(row_t'({TILE_W{1'b1}}) << nib_sh))
                     | (row_t'(tile_q) << nib_sh);
        ram_wren_d   = 1'b1;
        state_d      = WRITE;
      end
      WRITE: begin
        done_d[gidx_q] = 1'b1;
        state_d        = DONE;
      end
      DONE, ERR: begin
        ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gidx_q       <= '0;
      x_q          <= '0;
      tile_q       <= '0;
      rd_cnt_q     <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      old_tile_q   <= '0;
      busy_q       <= 1'b0;
      ram_addr_q   <= '0;
      ram_wrdata_q <= '0;
      ram_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gidx_q       <= gidx_d;
      x_q          <= x_d;
      tile_q       <= tile_d;
      rd_cnt_q     <= rd_cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      old_tile_q   <= old_tile_d;
      busy_q       <= busy_d;
      ram_addr_q   <= ram_addr_d;
      ram_wrdata_q <= ram_wrdata_d;
      ram_wren_q   <= ram_wren_d;
    end
  end

  assign done       = done_q;
  assign err        = err_q;
  assign old_tile   = old_tile_q;
  assign busy       = busy_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wrdata = ram_wrdata_q;
  assign ram_wren   = ram_wren_q;

endmodule

// File: tb/tb_map_tile_arbiter.sv
// Self-checking bench for map_tile_arbiter: a transaction-level model
// predicts every output each cycle, and directed tests pin cycle numbers
// and data values with hand-computed literals.
`timescale 1ns/1ps
module tb_map_tile_arbiter;
  import map_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int ROWS    = 30;
  localparam int COLS    = 40;
  localparam int RD_LAT  = 1;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset    = 1'b1;
  logic [NUM_REQ-1:0]   req      = '0;
  logic [NUM_REQ*6-1:0] req_x;
  logic [NUM_REQ*5-1:0] req_y;
  logic [NUM_REQ*4-1:0] req_tile;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic [3:0]           old_tile;
  logic                 busy;
  logic [4:0]           ram_addr;
  logic [159:0]         ram_wrdata;
  logic                 ram_wren;
  logic [159:0]         ram_rddata;

  logic [5:0] rx [NUM_REQ];
  logic [4:0] ry [NUM_REQ];
  tile_t      rt [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
    assign req_x[6*gi +: 6]    = rx[gi];
    assign req_y[5*gi +: 5]    = ry[gi];
    assign req_tile[4*gi +: 4] = rt[gi];
  end

  map_tile_arbiter #(.NUM_REQ(NUM_REQ), .ROWS(ROWS), .COLS(COLS), .RD_LAT(RD_LAT)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_tile   (req_tile),
    .done       (done),
    .err        (err),
    .old_tile   (old_tile),
    .busy       (busy),
    .ram_addr   (ram_addr),
    .ram_wrdata (ram_wrdata),
    .ram_wren   (ram_wren),
    .ram_rddata (ram_rddata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Deterministic initial map contents; row 5 holds only tile 2 at x=3.
  function automatic row_t row_init(input int r);
    row_t v;
    if (r == 5) return row_t'(160'h2) << 144;
    for (int n = 0; n < 40; n++) v[4*n +: 4] = 4'((r * 7 + n * 3) % 16);
    return v;
  endfunction

  // Map RAM behavioural model with RD_LAT cycles of read latency.
  row_t ram [ROWS];
  row_t rd_pipe [RD_LAT];
  assign ram_rddata = rd_pipe[RD_LAT-1];
  initial begin
    for (int r = 0; r < ROWS; r++) ram[r] = row_init(r);
    for (int p = 0; p < RD_LAT; p++) rd_pipe[p] = '0;
    forever begin
      @(posedge CLOCK_50);
      if (ram_wren && int'(ram_addr) < ROWS) ram[ram_addr] <= ram_wrdata;
      rd_pipe[0] <= (int'(ram_addr) < ROWS) ? ram[ram_addr] : '0;
      for (int p = 1; p < RD_LAT; p++) rd_pipe[p] <= rd_pipe[p-1];
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  row_t       ref_mem [ROWS];
  bit         m_act, m_valid, armed, rst_seen;
  int         m_start, m_g, m_ptr;
  logic [5:0] m_x;
  logic [4:0] m_y;
  tile_t      m_tile, m_old;

  // Events observed on the DUT, used by the directed literal checks.
  int   wren_count, ev_wren_cyc, ev_done_cyc;
  row_t ev_wrdata;
  logic [4:0] ev_addr;
  logic [NUM_REQ-1:0] ev_done_vec;
  tile_t ev_old;
  logic  ev_err;
  int done_log[$];
  int done_cyc_log[$];
  logic [NUM_REQ-1:0] keep = '0;

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
`ifdef MAP_TILE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NUM_REQ; k++) if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  task automatic model_step();
    bit idle_at_start;
    logic [NUM_REQ-1:0] e_done;
    bit e_err, e_busy, e_wren;
    int dc, wc, w;
    row_t exp_row;
    idle_at_start = !m_act;
    dc = m_valid ? m_start + RD_LAT + 3 : m_start + 1;
    wc = m_start + RD_LAT + 2;

    if (ram_wren) begin
      if (wren_count == 0) begin
        ev_wren_cyc = cyc;
        ev_wrdata   = ram_wrdata;
        ev_addr     = ram_addr;
      end
      wren_count++;
    end
    if (|done) begin
      ev_done_cyc = cyc;
      ev_done_vec = done;
      ev_old      = old_tile;
      ev_err      = err;
      for (int i = 0; i < NUM_REQ; i++) if (done[i]) done_log.push_back(i);
      done_cyc_log.push_back(cyc);
    end

    if (armed) begin
      e_done = '0;
      e_err  = 1'b0;
      e_busy = 1'b0;
      e_wren = 1'b0;
      if (m_act) begin
        e_busy = (cyc > m_start) && (cyc <= dc);
        e_wren = m_valid && (cyc == wc);
        if (cyc == dc) begin
          e_done[m_g] = 1'b1;
          e_err       = !m_valid;
        end
      end
      check("done", done, e_done);
      check("err", err, e_err);
      check("busy", busy, e_busy);
      check("ram_wren", ram_wren, e_wren);
      if (m_act && m_valid && e_busy) check("ram_addr", ram_addr, m_y);
      if (e_wren) begin
        exp_row = ref_mem[m_y];
        exp_row[159 - 4*int'(m_x) -: 4] = m_tile;
        check("ram_wrdata", ram_wrdata, exp_row);
        ref_mem[m_y] = exp_row;
      end
      if (|e_done) check("old_tile", old_tile, m_valid ? m_old : 4'h0);
      if (rst_seen) begin
        check("reset ram_addr", ram_addr, 0);
        check("reset ram_wrdata", ram_wrdata, 0);
        check("reset old_tile", old_tile, 0);
        rst_seen = 1'b0;
      end
      if (m_act && cyc == dc) begin
        m_act = 1'b0;
        m_ptr = (m_g + 1) % NUM_REQ;
      end
    end

    if (reset) begin
      m_act    = 1'b0;
      m_ptr    = 0;
      armed    = 1'b1;
      rst_seen = 1'b1;
    end else if (idle_at_start && req != '0) begin
      w       = pick(req, m_ptr);
      m_act   = 1'b1;
      m_start = cyc;
      m_g     = w;
      m_x     = rx[w];
      m_y     = ry[w];
      m_tile  = rt[w];
      m_valid = (int'(rx[w]) < COLS) && (int'(ry[w]) < ROWS);
      if (m_valid) m_old = ref_mem[ry[w]][159 - 4*int'(rx[w]) -: 4];
    end
  endtask

  // One clock cycle: check at the falling edge, then release completed requesters.
  task automatic tick();
    @(negedge CLOCK_50);
    model_step();
    @(posedge CLOCK_50);
    #2;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (done[i]) begin
        if (keep[i]) keep[i] = 1'b0;
        else         req[i]  = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input int x, input int y, input int t);
    rx[i]  = 6'(x);
    ry[i]  = 5'(y);
    rt[i]  = 4'(t);
    req[i] = 1'b1;
  endtask

  task automatic clear_ev();
    wren_count  = 0;
    ev_wren_cyc = -1;
    ev_done_cyc = -1;
    ev_wrdata   = '0;
    ev_addr     = '0;
    ev_done_vec = '0;
    ev_old      = '0;
    ev_err      = 1'b0;
    done_log.delete();
    done_cyc_log.delete();
  endtask

  task automatic run_until_quiet(input string name, input int budget);
    int n = 0;
    while ((req != '0 || m_act || busy) && n < budget) begin
      tick();
      n++;
    end
    check(name, n < budget, 1'b1);
    tick();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  int   t0;
  row_t exp_row_lit, r_ref;
  int   exp_order [4];

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rx[i] = '0;
      ry[i] = '0;
      rt[i] = '0;
    end
    for (int r = 0; r < ROWS; r++) ref_mem[r] = row_init(r);
    m_act = 0; m_valid = 0; armed = 0; rst_seen = 0; m_ptr = 0; m_start = 0; m_g = 0;
    clear_ev();

    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 3'b000);

    // Single write: row 5 x=3 tile 2 -> 7.
    clear_ev();
    t0 = cyc;
    set_req(0, 3, 5, 7);
    run_until_quiet("single quiet", 40);
    exp_row_lit = row_t'(160'h7) << 144;
    check("single wren cycle", ev_wren_cyc - t0, 3);
    check("single wren count", wren_count, 1);
    check("single wrdata", ev_wrdata, exp_row_lit);
    check("single addr", ev_addr, 5);
    check("single done cycle", ev_done_cyc - t0, 4);
    check("single done vec", ev_done_vec, 3'b001);
    check("single old_tile", ev_old, 4'h2);

    // Contention from a freshly reset pointer.
    reset_dut();
    clear_ev();
    t0 = cyc;
    set_req(0, 1, 1, 1);
    set_req(1, 2, 2, 2);
    set_req(2, 3, 3, 3);
    run_until_quiet("contend quiet", 60);
    check("contend count", done_log.size(), 3);
    if (done_log.size() == 3) begin
      check("contend order0", done_log[0], 0);
      check("contend order1", done_log[1], 1);
      check("contend order2", done_log[2], 2);
      check("contend first", done_cyc_log[0] - t0, 4);
      check("contend gap1", done_cyc_log[1] - done_cyc_log[0], 5);
      check("contend gap2", done_cyc_log[2] - done_cyc_log[1], 5);
    end

    // Requester 0 keeps its request after its first done.
    reset_dut();
    clear_ev();
    keep = 3'b001;
    set_req(0, 4, 1, 4);
    set_req(1, 5, 2, 5);
    set_req(2, 6, 3, 6);
    run_until_quiet("reraise quiet", 80);
`ifdef MAP_TILE_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 2};
`else
    exp_order = '{0, 1, 2, 0};
`endif
    check("reraise count", done_log.size(), 4);
    if (done_log.size() == 4)
      for (int k = 0; k < 4; k++) check($sformatf("reraise order%0d", k), done_log[k], exp_order[k]);

    // Out of range: x=40 and y=30.
    clear_ev();
    t0 = cyc;
    set_req(1, 40, 0, 9);
    run_until_quiet("oor x quiet", 20);
    check("oor x done cycle", ev_done_cyc - t0, 1);
    check("oor x done vec", ev_done_vec, 3'b010);
    check("oor x err", ev_err, 1'b1);
    check("oor x old_tile", ev_old, 4'h0);
    check("oor x wren count", wren_count, 0);
    clear_ev();
    set_req(2, 0, 30, 1);
    run_until_quiet("oor y quiet", 20);
    check("oor y err", ev_err, 1'b1);
    check("oor y wren count", wren_count, 0);

    // Edges: x=0 at y=0, x=39 at y=29.
    clear_ev();
    set_req(0, 0, 0, 10);
    run_until_quiet("edge x0 quiet", 20);
    r_ref = row_init(0);
    check("edge x0 nibble", ev_wrdata[159:156], 4'hA);
    check("edge x0 rest", ev_wrdata[155:0], r_ref[155:0]);
    clear_ev();
    set_req(1, 39, 29, 5);
    run_until_quiet("edge x39 quiet", 20);
    r_ref = row_init(29);
    check("edge x39 nibble", ev_wrdata[3:0], 4'h5);
    check("edge x39 rest", ev_wrdata[159:4], r_ref[159:4]);
    check("edge y29 addr", ev_addr, 29);
    check("edge y29 old_tile", ev_old, r_ref[3:0]);

    // Reset at the edge that would enter WRITE aborts the update.
    clear_ev();
    set_req(2, 10, 7, 12);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = '0;
    for (int k = 0; k < 6; k++) tick();
    check("abort wren count", wren_count, 0);
    check("abort done count", done_log.size(), 0);
    clear_ev();
    t0 = cyc;
    set_req(2, 10, 7, 12);
    run_until_quiet("after abort quiet", 20);
    check("after abort done cycle", ev_done_cyc - t0, 4);
    check("after abort nibble", ev_wrdata[119:116], 4'hC);

    // A request raised while busy waits its turn.
    clear_ev();
    set_req(1, 5, 10, 3);
    tick();
    tick();
    set_req(0, 6, 10, 4);
    run_until_quiet("late quiet", 40);
    check("late count", done_log.size(), 2);
    if (done_log.size() == 2) begin
      check("late order0", done_log[0], 1);
      check("late order1", done_log[1], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
